muxnway_rr: RTL and testbench
=============================

Name: muxnway_rr

Overview:
- Parametrised successor to the fixed 8-way 16-bit selector.
- WAYS input channels of WIDTH bits, each with a valid/ready handshake, feed one registered output channel.
- Channel choice is round-robin, or software-fixed via `sel`.
- Sits between multiple producers (e.g. memory-mapped peripherals) and a single consumer; 1-cycle registered latency.

Parameters:
- WIDTH, 16, data bits per channel.
- WAYS, 8, number of input channels (2..64, need not be a power of two).
- SEL_W, $clog2(WAYS), select/index width (localparam, derived; not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  WAYS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  WAYS  per-channel valid.
- in_ready  output  WAYS  per-channel ready; at most one bit set.
- sel_mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SEL_W  channel used when sel_mode=1.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts beat.
- out_sel  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
- Load enable: load = ~out_valid | out_ready.
- Grant, round-robin mode:
  - grant = first i with in_valid[i] set, scanning ptr, ptr+1, …, WAYS-1, 0, …, ptr-1.
  - No valid channel → no grant.
- Grant, fixed mode:
  - grant = sel if sel < WAYS and in_valid[sel]; otherwise no grant.
  - sel >= WAYS never grants.
- in_ready[i] = (i == grant) & grant exists & load. Combinational from in_valid, sel, sel_mode, ptr, out_valid, out_ready.
- Transfer on channel g when in_valid[g] & in_ready[g]. Next edge:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - Round-robin mode only: ptr <= (g == WAYS-1) ? 0 : g+1.
- Drain without new transfer (out_valid & out_ready, no grant): out_valid <= 0; out_data and out_sel hold.
- Simultaneous drain and transfer: full throughput, one beat per cycle, out_valid stays 1.
- Output stalled (out_valid & ~out_ready):
  - All in_ready=0.
  - out_data and out_sel hold.
  - ptr holds.
- Fixed mode leaves ptr unchanged. Switching sel_mode takes effect on the next grant computation; no beat is lost or duplicated.
- Producers must hold in_valid/in_data until accepted. Grant may move to another channel while a requester is not yet accepted; that does not violate the protocol.
- Reset asserted mid-transfer drops the output beat immediately (out_valid=0 asynchronously).

Optional Feature:
- Macro: MUXNWAY_RR_LOCK_EN.
- Defined:
  - Adds ports in_last (input, WAYS) and out_last (output, 1, registered alongside out_data; reset 0).
  - After a transfer from channel g with in_last[g]=0, arbitration locks to g: grant = g only, regardless of mode/ptr/sel, until a beat from g with in_last[g]=1 is transferred.
  - While locked, ptr does not advance. On the last beat, ptr <= g+1 (wrapped) in round-robin mode.
  - Reset clears the lock.
- Not defined: no in_last/out_last ports; every beat is arbitrated independently as above.

Test Plan:
- Reset, then all in_valid=0 → out_valid=0, out_data=0, in_ready=0; reset_n pulse mid-beat clears out_valid without waiting for clk.
- WAYS=8, round-robin, in_valid=8'hFF, out_ready=1, in_data[i]=16'h1000+i → out_sel sequence 0,1,…,7,0 on consecutive cycles; out_data=16'h1000+out_sel; one beat per cycle.
- Round-robin, in_valid=8'b1000_0100, ptr=3 → channel 2 (data 16'h00AA) is skipped first; grant order 7 then 2, then 7 again.
- Fixed mode, sel=5, in_valid[5]=1 with data 16'hBEEF, out_ready=0 for 3 cycles → out_data=16'hBEEF held, out_valid=1, all in_ready=0; then out_ready=1 drains. Fixed mode sel=5 with in_valid[5]=0 → no grant.
- WAYS=5 (non power of two), round-robin, all valid → out_sel wraps 4→0; fixed sel=6 → never grants.
- MUXNWAY_RR_LOCK_EN: channel 1 sends 3 beats (in_last on the 3rd) while channel 2 valid throughout → out_sel 1,1,1,2; out_last=1 on the 3rd beat only.

Source files
------------

// File: rtl/muxnway_rr.sv
// WAYS-to-1 valid/ready selector with round-robin or fixed-select arbitration and a registered output.
// Optional packet locking (in_last/out_last) is enabled by defining MUXNWAY_RR_LOCK_EN.
module muxnway_rr #(
    parameter  int WIDTH = 16,
    parameter  int WAYS  = 8,
    localparam int SEL_W = $clog2(WAYS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WAYS*WIDTH-1:0] in_data,
    input  logic [WAYS-1:0]       in_valid,
    output logic [WAYS-1:0]       in_ready,
`ifdef MUXNWAY_RR_LOCK_EN
    input  logic [WAYS-1:0]       in_last,
    output logic                  out_last,
`endif
    input  logic                  sel_mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_sel
);

    localparam int NPAD = 1 << SEL_W;

    logic [WIDTH-1:0] chan [WAYS];
    logic [NPAD-1:0]  valid_pad;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_vld;
    logic             load;
    logic             xfer;
    logic [SEL_W-1:0] ptr_next;
    int               j;

    for (genvar i = 0; i < WAYS; i++) begin : g_chan
        assign chan[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Padding to a power of two makes valid_pad[sel] read 0 for any sel >= WAYS.
    assign valid_pad = NPAD'(in_valid);
    assign load      = ~out_valid | out_ready;

    // Descending scan so the channel closest to ptr (smallest offset) wins.
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        j      = 0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= WAYS) j = j - WAYS;
            if (valid_pad[SEL_W'(j)]) begin
                rr_vld = 1'b1;
                rr_idx = SEL_W'(j);
            end
        end
    end

`ifdef MUXNWAY_RR_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_ch;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (locked) begin
            grant_vld = valid_pad[lock_ch];
            grant_idx = lock_ch;
        end else if (sel_mode) begin
            grant_vld = valid_pad[sel];
            grant_idx = sel;
        end else begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end
    end
`else
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (sel_mode) begin
            grant_vld = valid_pad[sel];
            grant_idx = sel;
        end else begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end
    end
`endif

    assign xfer     = grant_vld & load;
    assign ptr_next = (grant_idx == SEL_W'(WAYS - 1)) ? '0 : grant_idx + SEL_W'(1);

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= chan[grant_idx];
            out_sel   <= grant_idx;
`ifdef MUXNWAY_RR_LOCK_EN
            // Pointer moves only when a packet closes; mid-packet beats leave it alone.
            if (!sel_mode && in_last[grant_idx]) ptr <= ptr_next;
`else
            if (!sel_mode) ptr <= ptr_next;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUXNWAY_RR_LOCK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked   <= 1'b0;
            lock_ch  <= '0;
            out_last <= 1'b0;
        end else if (xfer) begin
            locked   <= ~in_last[grant_idx];
            lock_ch  <= grant_idx;
            out_last <= in_last[grant_idx];
        end
    end
`endif

endmodule

// File: tb/tb_muxnway_rr.sv
// Directed testbench for muxnway_rr: an 8-way and a 5-way instance with hand-computed expectations.
module tb_muxnway_rr;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [127:0] in_data;
    logic [7:0]   in_valid;
    logic [7:0]   in_ready;
    logic         sel_mode;
    logic [2:0]   sel;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_sel;
    logic [7:0]   in_last;
    logic         out_last;

    logic [79:0]  in_data5;
    logic [4:0]   in_valid5;
    logic [4:0]   in_ready5;
    logic         sel_mode5;
    logic [2:0]   sel5;
    logic [15:0]  out_data5;
    logic         out_valid5;
    logic         out_ready5;
    logic [2:0]   out_sel5;
    logic [4:0]   in_last5;
    logic         out_last5;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muxnway_rr #(.WIDTH(16), .WAYS(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready),
`ifdef MUXNWAY_RR_LOCK_EN
        .in_last(in_last), .out_last(out_last),
`endif
        .sel_mode(sel_mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sel(out_sel)
    );

    muxnway_rr #(.WIDTH(16), .WAYS(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data5), .in_valid(in_valid5),
        .in_ready(in_ready5),
`ifdef MUXNWAY_RR_LOCK_EN
        .in_last(in_last5), .out_last(out_last5),
`endif
        .sel_mode(sel_mode5), .sel(sel5), .out_data(out_data5), .out_valid(out_valid5),
        .out_ready(out_ready5), .out_sel(out_sel5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        in_data    = '0;
        in_valid   = '0;
        sel_mode   = 1'b0;
        sel        = '0;
        out_ready  = 1'b0;
        in_last    = '0;
        in_data5   = '0;
        in_valid5  = '0;
        sel_mode5  = 1'b0;
        sel5       = '0;
        out_ready5 = 1'b0;
        in_last5   = '0;

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sel", 32'(out_sel), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_valid5", 32'(out_valid5), 32'd0);
        reset_n = 1'b1;
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Round-robin, all channels valid: 0..7 then wrap to 0
        for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = 16'h1000 + 16'(i);
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        #1 chk("rr_first_ready", 32'(in_ready), 32'h01);
        for (int k = 0; k < 9; k++) begin
            step();
            chk("rr_valid", 32'(out_valid), 32'd1);
            chk("rr_sel", 32'(out_sel), 32'(k % 8));
            chk("rr_data", 32'(out_data), 32'h1000 + 32'(k % 8));
        end
        in_valid = '0;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_sel_hold", 32'(out_sel), 32'd0);

        // ptr is now 1; a lone grant on channel 2 moves it to 3
        in_data[2*16 +: 16] = 16'h00AA;
        in_data[7*16 +: 16] = 16'h0077;
        in_valid = 8'h04;
        step();
        chk("skip_pre_sel", 32'(out_sel), 32'd2);
        in_valid = 8'h84;
        #1 chk("skip_ready7", 32'(in_ready), 32'h80);
        step();
        chk("skip_sel7", 32'(out_sel), 32'd7);
        chk("skip_data7", 32'(out_data), 32'h0077);
        chk("skip_ready2", 32'(in_ready), 32'h04);
        step();
        chk("skip_sel2", 32'(out_sel), 32'd2);
        chk("skip_data2", 32'(out_data), 32'h00AA);
        chk("skip_ready7b", 32'(in_ready), 32'h80);
        step();
        chk("skip_sel7b", 32'(out_sel), 32'd7);
        in_valid = '0;
        step();
        chk("skip_drain", 32'(out_valid), 32'd0);

        // Fixed select 5 with a stalled consumer
        sel_mode = 1'b1;
        sel      = 3'd5;
        in_data[5*16 +: 16] = 16'hBEEF;
        in_valid  = 8'h20;
        out_ready = 1'b0;
        step();
        chk("fix_valid", 32'(out_valid), 32'd1);
        chk("fix_data", 32'(out_data), 32'hBEEF);
        chk("fix_sel", 32'(out_sel), 32'd5);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'hBEEF);
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = '0;
        step();
        chk("fix_drain", 32'(out_valid), 32'd0);
        chk("fix_data_hold", 32'(out_data), 32'hBEEF);
        in_valid = 8'h10;
        #1 chk("fix_nogrant_ready", 32'(in_ready), 32'd0);
        step();
        chk("fix_nogrant_valid", 32'(out_valid), 32'd0);
        // Fixed-mode grants must not have moved ptr away from 0
        sel_mode = 1'b0;
        in_valid = 8'h81;
        #1 chk("ptr_kept", 32'(in_ready), 32'h01);
        in_valid = '0;

        // Non power-of-two: 5 ways
        for (int i = 0; i < 5; i++) in_data5[i*16 +: 16] = 16'h0500 + 16'(i);
        in_valid5  = 5'h1F;
        out_ready5 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("w5_sel", 32'(out_sel5), 32'(k % 5));
            chk("w5_data", 32'(out_data5), 32'h0500 + 32'(k % 5));
        end
        sel_mode5 = 1'b1;
        sel5      = 3'd6;
        #1 chk("w5_sel6_ready", 32'(in_ready5), 32'd0);
        step();
        chk("w5_sel6_valid", 32'(out_valid5), 32'd0);
        in_valid5 = '0;

`ifdef MUXNWAY_RR_LOCK_EN
        // Channel 1 sends a 3-beat packet while channel 2 competes
        step();
        in_data[1*16 +: 16] = 16'h1111;
        in_data[2*16 +: 16] = 16'h2222;
        in_valid = 8'h06;
        in_last  = 8'h00;
        step();
        chk("lock_sel1", 32'(out_sel), 32'd1);
        chk("lock_last1", 32'(out_last), 32'd0);
        step();
        chk("lock_sel2nd", 32'(out_sel), 32'd1);
        chk("lock_last2", 32'(out_last), 32'd0);
        in_last = 8'h02;
        step();
        chk("lock_sel3rd", 32'(out_sel), 32'd1);
        chk("lock_last3", 32'(out_last), 32'd1);
        in_valid = 8'h04;
        in_last  = 8'h00;
        step();
        chk("lock_sel_ch2", 32'(out_sel), 32'd2);
        chk("lock_data_ch2", 32'(out_data), 32'h2222);
        chk("lock_last_ch2", 32'(out_last), 32'd0);
        in_valid = '0;
        step();
`endif

        // Asynchronous reset while a beat is held
        in_valid  = 8'h01;
        out_ready = 1'b0;
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        in_valid = '0;
        #2 reset_n = 1'b0;
        #1 chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
